// File: rtl/npc_pkg.sv
// Shared encodings and constants for the next-PC generator.
// FSM states, redirect-source codes and instruction-field widths.
package npc_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_J    = 2'd2,
    SRC_JR   = 2'd3
  } src_e;

  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned JIDX_W     = 26;
  localparam int unsigned BOFF_W     = 16;

endpackage

// File: rtl/npc_target.sv
// Combinational redirect target, source select and link address.
// NPC_DELAY_SLOT_EN: link is br_pc+8 and the delay-slot pc is exported.
module npc_target
  import npc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              br_valid_i,
  input  logic              br_taken_i,
  input  logic [XLEN-1:0]   br_pc_i,
  input  logic [BOFF_W-1:0] br_imm_i,
  input  logic              j_valid_i,
  input  logic [JIDX_W-1:0] j_imm_i,
  input  logic              jr_valid_i,
  input  logic [XLEN-1:0]   jr_target_i,
  output src_e              src_o,
  output logic [XLEN-1:0]   target_o,
  output logic              misalign_o,
`ifdef NPC_DELAY_SLOT_EN
  output logic [XLEN-1:0]   seq_pc_o,
`endif
  output logic [XLEN-1:0]   link_addr_o
);

  logic [XLEN-1:0] seq;
  logic [XLEN-1:0] boff;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;
  logic [XLEN-1:0] jr_tgt;

  assign seq  = br_pc_i + XLEN'(INSN_BYTES);
  assign boff = {{(XLEN-BOFF_W-2){br_imm_i[BOFF_W-1]}},
                 br_imm_i, 2'b00};

  assign br_tgt = seq + boff;
  assign j_tgt  = {seq[XLEN-1:JIDX_W+2], j_imm_i, 2'b00};
  assign jr_tgt = {jr_target_i[XLEN-1:2], 2'b00};

  // Fixed priority: jr over j over taken branch
  always_comb begin
    src_o = SRC_NONE;
    if (jr_valid_i)
      src_o = SRC_JR;
    else if (j_valid_i)
      src_o = SRC_J;
    else if (br_valid_i && br_taken_i)
      src_o = SRC_BR;
  end

  // Target mux driven by the selected source
  always_comb begin
    unique case (src_o)
      SRC_JR:  target_o = jr_tgt;
      SRC_J:   target_o = j_tgt;
      default: target_o = br_tgt;
    endcase
  end

  assign misalign_o = jr_valid_i && (jr_target_i[1:0] != 2'b00);

`ifdef NPC_DELAY_SLOT_EN
  assign seq_pc_o    = seq;
  assign link_addr_o = br_pc_i + XLEN'(2 * INSN_BYTES);
`else
  assign link_addr_o = seq;
`endif

endmodule

// File: rtl/pc_gen.sv
// PC register, boot/run FSM and fetch handshake.
// NPC_DELAY_SLOT_EN: adds PEND state holding a deferred target.
module pc_gen
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_ready,
  output logic [XLEN-1:0]   pc,
  output logic              pc_valid,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_pc,
  input  logic [BOFF_W-1:0] br_imm,
  input  logic              j_valid,
  input  logic [JIDX_W-1:0] j_imm,
  input  logic              jr_valid,
  input  logic [XLEN-1:0]   jr_target,
  output logic [XLEN-1:0]   link_addr,
  output logic              flush,
  output logic              misalign
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;
  src_e            src;
  logic [XLEN-1:0] target;
  logic            mis_req;
  logic            redirect;
  logic            fire;
`ifdef NPC_DELAY_SLOT_EN
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] seq_pc;
`endif

  npc_target #(
    .XLEN (XLEN)
  ) u_target (
    .br_valid_i  (br_valid),
    .br_taken_i  (br_taken),
    .br_pc_i     (br_pc),
    .br_imm_i    (br_imm),
    .j_valid_i   (j_valid),
    .j_imm_i     (j_imm),
    .jr_valid_i  (jr_valid),
    .jr_target_i (jr_target),
    .src_o       (src),
    .target_o    (target),
    .misalign_o  (mis_req),
`ifdef NPC_DELAY_SLOT_EN
    .seq_pc_o    (seq_pc),
`endif
    .link_addr_o (link_addr)
  );

  assign redirect = (src != SRC_NONE);
  assign fire     = pc_valid_q && fetch_ready;

  // Next-state: boot, sequential advance and redirects
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    flush_d    = 1'b0;
    mis_d      = 1'b0;
`ifdef NPC_DELAY_SLOT_EN
    tgt_d      = tgt_q;
`endif
    unique case (state_q)
      ST_BOOT: begin
        pc_valid_d = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          mis_d = mis_req;
`ifdef NPC_DELAY_SLOT_EN
          if (pc_q == seq_pc) begin
            if (fire) begin
              pc_d = target;
            end else begin
              tgt_d   = target;
              state_d = ST_PEND;
            end
          end else begin
            pc_d    = target;
            flush_d = 1'b1;
          end
`else
          pc_d    = target;
          flush_d = 1'b1;
`endif
        end else if (fire) begin
          pc_d = pc_q + XLEN'(INSN_BYTES);
        end
      end
`ifdef NPC_DELAY_SLOT_EN
      ST_PEND: begin
        if (redirect) begin
          tgt_d = target;
          mis_d = mis_req;
        end
        if (fire) begin
          pc_d    = redirect ? target : tgt_q;
          state_d = ST_RUN;
        end
      end
`endif
      default: state_d = ST_BOOT;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
`ifdef NPC_DELAY_SLOT_EN
      tgt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      mis_q      <= mis_d;
`ifdef NPC_DELAY_SLOT_EN
      tgt_q      <= tgt_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign flush    = flush_q;
  assign misalign = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen, no-delay-slot build.
// Expected pc/valid/flush/misalign are queued per step, checked at negedge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [15:0] br_imm;
  logic        j_valid;
  logic [25:0] j_imm;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic [31:0] link_addr;
  logic        flush;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        v;
    logic        f;
    logic        m;
  } exp_t;

  exp_t sb[$];

  pc_gen #(
    .XLEN     (32),
    .RESET_PC (32'h0000_3000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_ready (fetch_ready),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_imm      (br_imm),
    .j_valid     (j_valid),
    .j_imm       (j_imm),
    .jr_valid    (jr_valid),
    .jr_target   (jr_target),
    .link_addr   (link_addr),
    .flush       (flush),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] p,
                      input logic v, input logic f, input logic m);
    exp_t e;
    e.tag = tag;
    e.pc  = p;
    e.v   = v;
    e.f   = f;
    e.m   = m;
    sb.push_back(e);
  endtask

  task automatic cmp();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert ({pc, pc_valid, flush, misalign} ===
            {e.pc, e.v, e.f, e.m})
    else begin
      errors++;
      $error("FAIL %s: got pc=%h v=%b f=%b m=%b want pc=%h v=%b f=%b m=%b",
             e.tag, pc, pc_valid, flush, misalign,
             e.pc, e.v, e.f, e.m);
    end
  endtask

  task automatic chk_link(input string tag, input logic [31:0] x);
    checks++;
    assert (link_addr === x)
    else begin
      errors++;
      $error("FAIL %s: got link=%h want %h", tag, link_addr, x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    j_valid   = 1'b0;
    jr_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_ready = 1'b1;
    br_pc = '0;
    br_imm = '0;
    j_imm = '0;
    jr_target = '0;
    idle();
    repeat (2) @(negedge clk);
    push("reset", 32'h3000, 0, 0, 0);
    cmp();

    rst = 1'b0;
    push("boot", 32'h3000, 1, 0, 0);
    tick(); cmp();
    push("seq1", 32'h3004, 1, 0, 0);
    tick(); cmp();
    push("seq2", 32'h3008, 1, 0, 0);
    tick(); cmp();

    fetch_ready = 1'b0;
    push("stall", 32'h3008, 1, 0, 0);
    tick(); cmp();

    br_valid = 1'b1;
    br_taken = 1'b1;
    br_pc    = 32'h3010;
    br_imm   = 16'hFFFC;
    #1 chk_link("br_link", 32'h3014);
    push("br_taken_stall", 32'h3004, 1, 1, 0);
    tick(); cmp();
    idle();
    push("flush_drop", 32'h3004, 1, 0, 0);
    tick(); cmp();

    fetch_ready = 1'b1;
    br_valid = 1'b1;
    br_taken = 1'b0;
    push("br_not_taken", 32'h3008, 1, 0, 0);
    tick(); cmp();

    jr_valid  = 1'b1;
    j_valid   = 1'b1;
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    jr_target = 32'h0000_4003;
    j_imm     = 26'h0000_123;
    push("priority", 32'h4000, 1, 1, 1);
    tick(); cmp();

    idle();
    j_valid = 1'b1;
    br_pc   = 32'h3FFF_FFFC;
    j_imm   = 26'h1;
    #1 chk_link("j_link", 32'h4000_0000);
    push("jump_b2b", 32'h4000_0004, 1, 1, 0);
    tick(); cmp();

    idle();
    push("after_jump", 32'h4000_0008, 1, 0, 0);
    tick(); cmp();

    jr_valid  = 1'b1;
    jr_target = 32'hFFFF_FFFC;
    push("jr_top", 32'hFFFF_FFFC, 1, 1, 0);
    tick(); cmp();
    idle();
    push("wrap", 32'h0000_0000, 1, 0, 0);
    tick(); cmp();

    br_valid = 1'b1;
    br_taken = 1'b1;
    br_pc    = 32'h0000_0100;
    br_imm   = 16'h0003;
    push("br_fwd", 32'h0000_0110, 1, 1, 0);
    tick(); cmp();
    idle();
    fetch_ready = 1'b0;
    push("hold", 32'h0000_0110, 1, 0, 0);
    tick(); cmp();

    #2 rst = 1'b1;
    #1 push("async_rst", 32'h3000, 0, 0, 0);
    cmp();
    @(negedge clk);
    rst = 1'b0;
    fetch_ready = 1'b1;
    j_valid = 1'b1;
    j_imm   = 26'h5;
    push("boot_ignores_j", 32'h3000, 1, 0, 0);
    tick(); cmp();
    idle();
    push("boot_seq", 32'h3004, 1, 0, 0);
    tick(); cmp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
